axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares a single AXI read slave (memory slave, 4-bit ID) between NUM_MASTERS read requesters.
- AR channel: round-robin arbitration; granted request registered and presented to the slave.
- Master index encoded in upper ID bits; R beats routed back combinationally by ID.
- Global outstanding-burst limit matched to the slave's request queue depth.

Parameters:
- NUM_MASTERS, 2, number of requesters (1..4).
- AXI_ADDR_W, 64, address width.
- AXI_DATA_W, 128, data width.
- MAX_OUTSTANDING, 3, max accepted-but-not-completed bursts (≤ slave usable queue depth).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m_arvalid  in  NUM_MASTERS  per-master AR valid.
- m_arready  out  NUM_MASTERS  per-master AR ready (one-hot or zero).
- m_araddr  in  NUM_MASTERS*AXI_ADDR_W  packed addresses, master i at slice i.
- m_arlen  in  NUM_MASTERS*8  burst length-1.
- m_arsize  in  NUM_MASTERS*3  beat size.
- m_arburst  in  NUM_MASTERS*2  burst type.
- m_arid  in  NUM_MASTERS*2  master-local ID.
- m_rvalid  out  NUM_MASTERS  per-master R valid.
- m_rready  in  NUM_MASTERS  per-master R ready.
- m_rdata  out  AXI_DATA_W  shared R data (qualify with m_rvalid).
- m_rlast  out  1  shared last flag.
- m_rresp  out  2  shared response.
- m_rid  out  2  local ID = s_rid[1:0].
- s_arvalid  out  1  slave AR valid.
- s_arready  in  1  slave AR ready.
- s_araddr  out  AXI_ADDR_W  slave address.
- s_arlen  out  8  slave burst length.
- s_arsize  out  3  slave burst size.
- s_arburst  out  2  slave burst type.
- s_arid  out  4  {master index[1:0], local ID[1:0]}.
- s_rvalid  in  1  slave R valid.
- s_rready  out  1  slave R ready.
- s_rdata  in  AXI_DATA_W  slave R data.
- s_rlast  in  1  slave last beat.
- s_rresp  in  2  slave response.
- s_rid  in  4  slave R ID.
- err_bad_rid  out  1  one-cycle pulse, beat with invalid master index dropped.
- outstanding  out  3  current outstanding count.

Behaviour:
- Reset (async assert, sync-release usage): state=IDLE; s_arvalid=0; all s_ar* regs=0; rr_ptr=0; outstanding=0; err_bad_rid=0. m_arready=0 while in reset.
- States: IDLE, AR_HOLD.
- IDLE:
  - If any m_arvalid and outstanding<MAX_OUTSTANDING, pick the winner by round-robin starting at rr_ptr.
  - Assert m_arready[winner] combinationally this cycle; capture its fields into s_ar*; s_arid={winner,m_arid[winner]}.
  - Set s_arvalid=1, increment outstanding, rr_ptr=(winner+1)%NUM_MASTERS, go AR_HOLD.
  - Otherwise all m_arready=0.
- AR_HOLD:
  - s_ar* stable, all m_arready=0.
  - On s_arvalid&&s_arready: s_arvalid=0, go IDLE.
- AR latency: master handshake to s_arvalid high = 1 cycle. Peak rate: 1 AR per 2 cycles.
- Outstanding counter:
  - +1 on master AR capture; −1 on s_rvalid&&s_rready&&s_rlast.
  - Simultaneous +1 and −1 → unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows (a last beat at 0 leaves it at 0).
  - At limit, no capture until a last-beat handshake. Capture is possible the following cycle.
- R routing (combinational, no added latency):
  - idx=s_rid[3:2]. If idx<NUM_MASTERS: m_rvalid[idx]=s_rvalid, other m_rvalid=0, s_rready=m_rready[idx].
  - If idx≥NUM_MASTERS: s_rready=1, all m_rvalid=0, err_bad_rid registered pulse on each dropped beat. A dropped last beat still decrements outstanding.
  - m_rdata/m_rlast/m_rresp pass straight through; m_rid=s_rid[1:0].
- Ordering: the slave serves in order; the arbiter keeps no reorder state.
- Reset mid-burst: everything above cleared. The slave is reset by the same rst_n; no residual beats are expected.

Test Plan:
- Single request: m0 araddr=0x40, arlen=3, arid=1 → next cycle s_arvalid=1, s_araddr=0x40, s_arid=4'h1. 4 beats reach m_rvalid[0] with m_rid=1, m_rlast on beat 4; outstanding 1→0.
- Contention: m0 and m1 assert arvalid together after reset → m0 granted first (s_arid=4'h0|id0), m1 granted on the next IDLE (s_arid=4'h4|id1).
- Fairness: both masters hold arvalid for 8 grants with s_arready=1 → grant order 0,1,0,1,0,1,0,1.
- Limit: MAX_OUTSTANDING=3, slave R stalled → 3 ARs issued, 4th m_arready stays 0. After the first s_rlast handshake, the 4th is granted the next cycle; outstanding=3 again.
- Backpressure / bad ID:
  - s_rid=4'h5 with m_rready[1]=0 → s_rready=0, beat held.
  - s_rid=4'hC with NUM_MASTERS=2 → s_rready=1, no m_rvalid, err_bad_rid pulses 1 cycle.
- Reset: assert rst_n=0 during AR_HOLD with outstanding=2 → s_arvalid=0 immediately (async), outstanding=0, rr_ptr=0. After release, first grant goes to m0.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Round-robin AR arbiter sharing one AXI read slave among NUM_MASTERS requesters.
// The master index rides in s_arid[3:2] and steers R beats back combinationally.
module axi_read_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int AXI_ADDR_W      = 64,
    parameter int AXI_DATA_W      = 128,
    parameter int MAX_OUTSTANDING = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_arvalid,
    output logic [NUM_MASTERS-1:0]            m_arready,
    input  logic [NUM_MASTERS*AXI_ADDR_W-1:0] m_araddr,
    input  logic [NUM_MASTERS*8-1:0]          m_arlen,
    input  logic [NUM_MASTERS*3-1:0]          m_arsize,
    input  logic [NUM_MASTERS*2-1:0]          m_arburst,
    input  logic [NUM_MASTERS*2-1:0]          m_arid,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    input  logic [NUM_MASTERS-1:0]            m_rready,
    output logic [AXI_DATA_W-1:0]             m_rdata,
    output logic                              m_rlast,
    output logic [1:0]                        m_rresp,
    output logic [1:0]                        m_rid,
    output logic                              s_arvalid,
    input  logic                              s_arready,
    output logic [AXI_ADDR_W-1:0]             s_araddr,
    output logic [7:0]                        s_arlen,
    output logic [2:0]                        s_arsize,
    output logic [1:0]                        s_arburst,
    output logic [3:0]                        s_arid,
    input  logic                              s_rvalid,
    output logic                              s_rready,
    input  logic [AXI_DATA_W-1:0]             s_rdata,
    input  logic                              s_rlast,
    input  logic [1:0]                        s_rresp,
    input  logic [3:0]                        s_rid,
    output logic                              err_bad_rid,
    output logic [2:0]                        outstanding
);

    localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUTSTANDING);
    localparam logic [2:0] NUM_M_C   = 3'(NUM_MASTERS);

    typedef enum logic [0:0] {IDLE = 1'b0, AR_HOLD = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              rr_ptr_q, rr_ptr_d;
    logic [2:0]              outstanding_q, outstanding_d;
    logic                    s_arvalid_q, s_arvalid_d;
    logic [AXI_ADDR_W-1:0]   s_araddr_q, s_araddr_d;
    logic [7:0]              s_arlen_q, s_arlen_d;
    logic [2:0]              s_arsize_q, s_arsize_d;
    logic [1:0]              s_arburst_q, s_arburst_d;
    logic [3:0]              s_arid_q, s_arid_d;
    logic                    err_q, err_d;

    logic [3:0]              arvalid_ext_s;
    logic [3:0]              arready_ext_s;
    logic [3:0]              rready_ext_s;
    logic [3:0]              rvalid_ext_s;
    logic [1:0]              cand_s;
    logic [1:0]              winner_s;
    logic                    hit_s;
    logic                    found_s;
    logic                    grant_s;
    logic [AXI_ADDR_W-1:0]   sel_addr_s;
    logic [7:0]              sel_len_s;
    logic [2:0]              sel_size_s;
    logic [1:0]              sel_burst_s;
    logic [1:0]              sel_id_s;
    logic [1:0]              rid_idx_s;
    logic                    idx_ok_s;
    logic                    rlast_hs_s;

    // Round-robin winner search from rr_ptr_q, then mux the winner's AR fields.
    always_comb begin
        arvalid_ext_s                  = 4'b0000;
        arvalid_ext_s[NUM_MASTERS-1:0] = m_arvalid;
        cand_s      = 2'b00;
        hit_s       = 1'b0;
        found_s     = 1'b0;
        winner_s    = 2'b00;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand_s   = 2'((int'(rr_ptr_q) + k) % NUM_MASTERS);
            hit_s    = !found_s && arvalid_ext_s[cand_s];
            winner_s = hit_s ? cand_s : winner_s;
            found_s  = found_s | hit_s;
        end
        sel_addr_s  = '0;
        sel_len_s   = 8'h00;
        sel_size_s  = 3'b000;
        sel_burst_s = 2'b00;
        sel_id_s    = 2'b00;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sel_addr_s  = (winner_s == 2'(i)) ? m_araddr[i*AXI_ADDR_W +: AXI_ADDR_W] : sel_addr_s;
            sel_len_s   = (winner_s == 2'(i)) ? m_arlen[i*8 +: 8]                    : sel_len_s;
            sel_size_s  = (winner_s == 2'(i)) ? m_arsize[i*3 +: 3]                   : sel_size_s;
            sel_burst_s = (winner_s == 2'(i)) ? m_arburst[i*2 +: 2]                  : sel_burst_s;
            sel_id_s    = (winner_s == 2'(i)) ? m_arid[i*2 +: 2]                     : sel_id_s;
        end
        // rst_n gating keeps every m_arready low while reset is held.
        grant_s       = rst_n && (state_q == IDLE) && (outstanding_q < MAX_OUT_C) && found_s;
        arready_ext_s = grant_s ? (4'b0001 << winner_s) : 4'b0000;
    end

    // R routing by the index in s_rid[3:2]; beats with no such master are sunk.
    always_comb begin
        rid_idx_s                     = s_rid[3:2];
        idx_ok_s                      = ({1'b0, rid_idx_s} < NUM_M_C);
        rready_ext_s                  = 4'b0000;
        rready_ext_s[NUM_MASTERS-1:0] = m_rready;
        rvalid_ext_s = (idx_ok_s && s_rvalid) ? (4'b0001 << rid_idx_s) : 4'b0000;
        s_rready     = idx_ok_s ? rready_ext_s[rid_idx_s] : 1'b1;
        rlast_hs_s   = s_rvalid && s_rready && s_rlast;
        err_d        = s_rvalid && !idx_ok_s;
    end

    // AR FSM next state: capture the winner in IDLE, hold the request until accepted.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        s_arvalid_d = s_arvalid_q;
        s_araddr_d  = s_araddr_q;
        s_arlen_d   = s_arlen_q;
        s_arsize_d  = s_arsize_q;
        s_arburst_d = s_arburst_q;
        s_arid_d    = s_arid_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    s_araddr_d  = sel_addr_s;
                    s_arlen_d   = sel_len_s;
                    s_arsize_d  = sel_size_s;
                    s_arburst_d = sel_burst_s;
                    s_arid_d    = {winner_s, sel_id_s};
                    s_arvalid_d = 1'b1;
                    rr_ptr_d    = 2'((int'(winner_s) + 1) % NUM_MASTERS);
                    state_d     = AR_HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            AR_HOLD: begin
                if (s_arready) begin
                    s_arvalid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = AR_HOLD;
                end
            end
            default: begin
                s_arvalid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Outstanding burst count; a last beat at zero cannot underflow it.
    always_comb begin
        case ({grant_s, rlast_hs_s})
            2'b10:   outstanding_d = outstanding_q + 3'd1;
            2'b01:   outstanding_d = (outstanding_q == 3'd0) ? 3'd0 : outstanding_q - 3'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 2'b00;
            outstanding_q <= 3'd0;
            s_arvalid_q   <= 1'b0;
            s_araddr_q    <= '0;
            s_arlen_q     <= 8'h00;
            s_arsize_q    <= 3'b000;
            s_arburst_q   <= 2'b00;
            s_arid_q      <= 4'h0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            s_arvalid_q   <= s_arvalid_d;
            s_araddr_q    <= s_araddr_d;
            s_arlen_q     <= s_arlen_d;
            s_arsize_q    <= s_arsize_d;
            s_arburst_q   <= s_arburst_d;
            s_arid_q      <= s_arid_d;
            err_q         <= err_d;
        end
    end

    assign m_arready   = arready_ext_s[NUM_MASTERS-1:0];
    assign m_rvalid    = rvalid_ext_s[NUM_MASTERS-1:0];
    assign m_rdata     = s_rdata;
    assign m_rlast     = s_rlast;
    assign m_rresp     = s_rresp;
    assign m_rid       = s_rid[1:0];
    assign s_arvalid   = s_arvalid_q;
    assign s_araddr    = s_araddr_q;
    assign s_arlen     = s_arlen_q;
    assign s_arsize    = s_arsize_q;
    assign s_arburst   = s_arburst_q;
    assign s_arid      = s_arid_q;
    assign err_bad_rid = err_q;
    assign outstanding = outstanding_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: queue-level reference model compared every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_axi_read_arbiter;

    localparam int NM = 2;
    localparam int AW = 64;
    localparam int DW = 128;
    localparam int MO = 3;

    logic               clk;
    logic               rst_n;
    logic [NM-1:0]      m_arvalid;
    logic [NM-1:0]      m_arready;
    logic [NM*AW-1:0]   m_araddr;
    logic [NM*8-1:0]    m_arlen;
    logic [NM*3-1:0]    m_arsize;
    logic [NM*2-1:0]    m_arburst;
    logic [NM*2-1:0]    m_arid;
    logic [NM-1:0]      m_rvalid;
    logic [NM-1:0]      m_rready;
    logic [DW-1:0]      m_rdata;
    logic               m_rlast;
    logic [1:0]         m_rresp;
    logic [1:0]         m_rid;
    logic               s_arvalid;
    logic               s_arready;
    logic [AW-1:0]      s_araddr;
    logic [7:0]         s_arlen;
    logic [2:0]         s_arsize;
    logic [1:0]         s_arburst;
    logic [3:0]         s_arid;
    logic               s_rvalid;
    logic               s_rready;
    logic [DW-1:0]      s_rdata;
    logic               s_rlast;
    logic [1:0]         s_rresp;
    logic [3:0]         s_rid;
    logic               err_bad_rid;
    logic [2:0]         outstanding;

    axi_read_arbiter #(
        .NUM_MASTERS(NM), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .m_rresp(m_rresp), .m_rid(m_rid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .s_rresp(s_rresp), .s_rid(s_rid),
        .err_bad_rid(err_bad_rid), .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int grant_log[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending AR slot, a burst counter, next-priority master.
    bit             mdl_pend;
    int             mdl_pm;
    logic [1:0]     mdl_pid;
    logic [AW-1:0]  mdl_addr;
    logic [7:0]     mdl_len;
    logic [2:0]     mdl_size;
    logic [1:0]     mdl_burst;
    int             mdl_cnt;
    int             mdl_next;
    bit             mdl_err;

    function automatic int pick();
        for (int k = 0; k < NM; k++) begin
            int idx;
            idx = (mdl_next + k) % NM;
            if (m_arvalid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit exp_gnt();
        return !mdl_pend && (mdl_cnt < MO) && (pick() >= 0);
    endfunction

    function automatic logic [NM-1:0] exp_arready();
        logic [NM-1:0] r;
        r = '0;
        if (exp_gnt()) r[pick()] = 1'b1;
        return r;
    endfunction

    function automatic bit rid_ok();
        return int'(s_rid[3:2]) < NM;
    endfunction

    function automatic bit exp_sready();
        if (rid_ok()) return m_rready[int'(s_rid[3:2])];
        return 1'b1;
    endfunction

    function automatic logic [NM-1:0] exp_rvalid();
        logic [NM-1:0] r;
        r = '0;
        if (rid_ok() && s_rvalid) r[int'(s_rid[3:2])] = 1'b1;
        return r;
    endfunction

    function automatic bit hs_last();
        return s_rvalid && exp_sready() && s_rlast;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_pend <= 1'b0; mdl_pm <= 0; mdl_pid <= 2'b00; mdl_addr <= '0;
            mdl_len <= 8'h00; mdl_size <= 3'b000; mdl_burst <= 2'b00;
            mdl_cnt <= 0; mdl_next <= 0; mdl_err <= 1'b0;
        end else begin
            mdl_err <= s_rvalid && !rid_ok();
            if (mdl_pend) begin
                if (s_arready) mdl_pend <= 1'b0;
            end else if (exp_gnt()) begin
                mdl_pend  <= 1'b1;
                mdl_pm    <= pick();
                mdl_pid   <= m_arid[pick()*2 +: 2];
                mdl_addr  <= m_araddr[pick()*AW +: AW];
                mdl_len   <= m_arlen[pick()*8 +: 8];
                mdl_size  <= m_arsize[pick()*3 +: 3];
                mdl_burst <= m_arburst[pick()*2 +: 2];
                mdl_next  <= (pick() + 1) % NM;
            end
            if (exp_gnt() && !hs_last()) mdl_cnt <= mdl_cnt + 1;
            else if (hs_last() && !exp_gnt() && mdl_cnt > 0) mdl_cnt <= mdl_cnt - 1;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_arready", m_arready, exp_arready());
            for (int i = 0; i < NM; i++) if (m_arready[i]) grant_log.push_back(i);
            chk("s_arvalid", s_arvalid, mdl_pend);
            if (mdl_pend) begin
                chk("s_arid", s_arid, {2'(mdl_pm), mdl_pid});
                chk("s_araddr", s_araddr, mdl_addr);
                chk("s_arlen", s_arlen, mdl_len);
                chk("s_arsize", s_arsize, mdl_size);
                chk("s_arburst", s_arburst, mdl_burst);
            end
            chk("outstanding", outstanding, 3'(mdl_cnt));
            chk("m_rvalid", m_rvalid, exp_rvalid());
            chk("s_rready", s_rready, exp_sready());
            chk("err_bad_rid", err_bad_rid, mdl_err);
            chk("m_rdata", m_rdata, s_rdata);
            chk("m_rid", m_rid, s_rid[1:0]);
            chk("m_rlast", m_rlast, s_rlast);
            chk("m_rresp", m_rresp, s_rresp);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; m_arvalid = '0; m_rready = '0; s_arready = 1'b0;
        m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arid = '0;
        s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0; s_rresp = 2'b00; s_rid = 4'h0;
        m_arsize = {3'd3, 3'd4}; m_arburst = {2'd2, 2'd1};
        m_araddr[AW +: AW] = 64'h0000_1000_0000_0080;

        // Reset state
        #14;
        chk("rst_arready", m_arready, 2'b00);
        chk("rst_s_arvalid", s_arvalid, 1'b0);
        chk("rst_outstanding", outstanding, 3'd0);
        chk("rst_err", err_bad_rid, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single request from m0
        m_arvalid = 2'b01; m_araddr[0 +: AW] = 64'h40; m_arlen[0 +: 8] = 8'd3; m_arid[1:0] = 2'd1;
        #1 chk("single_arready", m_arready, 2'b01);
        cyc(1); m_arvalid = 2'b00;
        #1;
        chk("single_s_arvalid", s_arvalid, 1'b1);
        chk("single_s_araddr", s_araddr, 64'h40);
        chk("single_s_arid", s_arid, 4'h1);
        chk("single_s_arlen", s_arlen, 8'd3);
        chk("single_outstanding", outstanding, 3'd1);
        s_arready = 1'b1;
        cyc(1); s_arready = 1'b0;
        #1 chk("single_ar_done", s_arvalid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s_rvalid = 1'b1; s_rid = 4'h1; s_rdata = 128'(i + 256); s_rlast = (i == 3); m_rready = 2'b01;
            #1;
            chk("single_rvalid", m_rvalid, 2'b01);
            chk("single_rid", m_rid, 2'd1);
            chk("single_rlast", m_rlast, (i == 3) ? 1'b1 : 1'b0);
            cyc(1);
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1 chk("single_drain", outstanding, 3'd0);

        // Contention straight after reset
        do_reset();
        m_arvalid = 2'b11; m_arid = {2'd3, 2'd2}; s_arready = 1'b1;
        #1 chk("cont_first", m_arready, 2'b01);
        cyc(1);
        #1 chk("cont_arid0", s_arid, 4'h2);
        chk("cont_hold_noready", m_arready, 2'b00);
        cyc(1);
        #1 chk("cont_second", m_arready, 2'b10);
        cyc(1); m_arvalid = 2'b00;
        #1 chk("cont_arid1", s_arid, 4'h7);
        chk("cont_outstanding", outstanding, 3'd2);
        cyc(1);
        s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'h2; m_rready = 2'b11;
        #1 chk("cont_r0", m_rvalid, 2'b01);
        cyc(1); s_rid = 4'h7;
        #1 chk("cont_r1", m_rvalid, 2'b10);
        chk("cont_r1_id", m_rid, 2'd3);
        cyc(1); s_rvalid = 1'b0; s_rlast = 1'b0;
        #1 chk("cont_drain", outstanding, 3'd0);

        // Fairness: both masters request continuously, R returns last beats every cycle
        grant_log.delete();
        m_arvalid = 2'b11; s_arready = 1'b1;
        s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'h0; m_rready = 2'b11;
        cyc(16);
        m_arvalid = 2'b00; s_rvalid = 1'b0; s_rlast = 1'b0;
        cyc(2);
        chk("fair_count", 128'(grant_log.size()), 128'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk("fair_order", 128'(grant_log[i]), 128'(i % 2));

        // Outstanding limit with the slave R channel stalled
        do_reset();
        m_arvalid = 2'b01; s_arready = 1'b1; m_rready = 2'b00;
        cyc(7);
        #1 chk("limit_blocked", m_arready, 2'b00);
        chk("limit_full", outstanding, 3'd3);
        s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'h0; m_rready = 2'b01;
        #1 chk("limit_same_cycle", m_arready, 2'b00);
        cyc(1); s_rvalid = 1'b0; s_rlast = 1'b0;
        #1 chk("limit_after_last", outstanding, 3'd2);
        chk("limit_regrant", m_arready, 2'b01);
        cyc(1); m_arvalid = 2'b00;
        #1 chk("limit_refull", outstanding, 3'd3);
        cyc(1);
        s_rvalid = 1'b1; s_rlast = 1'b1;
        cyc(3); s_rvalid = 1'b0; s_rlast = 1'b0;
        #1 chk("limit_drain", outstanding, 3'd0);

        // Backpressure from m1, then a beat with an out-of-range master index
        s_rvalid = 1'b1; s_rid = 4'h5; s_rlast = 1'b0; m_rready = 2'b01;
        #1 chk("bp_sready", s_rready, 1'b0);
        chk("bp_rvalid", m_rvalid, 2'b10);
        cyc(2);
        #1 chk("bp_held", m_rvalid, 2'b10);
        m_rready = 2'b11;
        #1 chk("bp_release", s_rready, 1'b1);
        cyc(1); s_rvalid = 1'b0;
        m_arvalid = 2'b10;
        cyc(1); m_arvalid = 2'b00;
        cyc(1);
        #1 chk("bad_pre", outstanding, 3'd1);
        s_rvalid = 1'b1; s_rid = 4'hC; s_rlast = 1'b1; m_rready = 2'b00;
        #1 chk("bad_sready", s_rready, 1'b1);
        chk("bad_rvalid", m_rvalid, 2'b00);
        chk("bad_err_early", err_bad_rid, 1'b0);
        cyc(1); s_rvalid = 1'b0; s_rlast = 1'b0;
        #1 chk("bad_err_pulse", err_bad_rid, 1'b1);
        chk("bad_dec", outstanding, 3'd0);
        cyc(1);
        #1 chk("bad_err_clear", err_bad_rid, 1'b0);

        // Asynchronous reset during AR_HOLD with two bursts outstanding
        m_arvalid = 2'b01; s_arready = 1'b1;
        cyc(2); s_arready = 1'b0;
        cyc(1); m_arvalid = 2'b00;
        #1 chk("rst_mid_hold", s_arvalid, 1'b1);
        chk("rst_mid_cnt", outstanding, 3'd2);
        m_arvalid = 2'b11;
        #2 rst_n = 1'b0;
        #1 chk("rst_async_arvalid", s_arvalid, 1'b0);
        chk("rst_async_cnt", outstanding, 3'd0);
        chk("rst_async_arready", m_arready, 2'b00);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("rst_first_m0", m_arready, 2'b01);
        cyc(1); m_arvalid = 2'b00;
        #1 chk("rst_first_arid", s_arid, 4'h2);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
